// File: rtl/oai222_x2_if.sv
// Self-test control and status bundle for the oai222_x2 cell wrapper.
// The master requests a run and the slave (the cell) reports its progress.
interface oai222_x2_if;
  logic bist_start;
  logic bist_busy;
  logic bist_done;
  logic bist_fail;

  modport master (
    output bist_start,
    input  bist_busy,
    input  bist_done,
    input  bist_fail
  );

  modport slave (
    input  bist_start,
    output bist_busy,
    output bist_done,
    output bist_fail
  );
endinterface

// File: rtl/oai222_x2.sv
// OAI222 cell, ZN = ~((A1|A2)&(B1|B2)&(C1|C2)), with a registered output copy
// and an exhaustive 64-vector self-test that checks the core against a sum-of-products form.
module oai222_x2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A1,
  input  logic       A2,
  input  logic       B1,
  input  logic       B2,
  input  logic       C1,
  input  logic       C2,
  output logic       ZN,
  output logic       zn_q,
  oai222_x2_if.slave bist
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       fail_q, fail_d;
  logic       busy;
  logic       done;
  logic [5:0] core_in;
  logic       core_zn;
  logic       ref_zn;

  assign busy = (state_q == S_RUN);
  assign done = busy && (cnt_q == 6'd63);

  // During self-test the counter drives the core as {A1,A2,B1,B2,C1,C2}.
  assign core_in = busy ? cnt_q : {A1, A2, B1, B2, C1, C2};

  assign core_zn = ~((core_in[5] | core_in[4]) &
                     (core_in[3] | core_in[2]) &
                     (core_in[1] | core_in[0]));

  assign ref_zn = (~core_in[5] & ~core_in[4]) |
                  (~core_in[3] & ~core_in[2]) |
                  (~core_in[1] & ~core_in[0]);

  assign ZN = core_zn;

  assign bist.bist_busy = busy;
  assign bist.bist_done = done;
  assign bist.bist_fail = fail_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (bist.bist_start) begin
          state_d = S_RUN;
          cnt_d   = 6'd0;
          fail_d  = 1'b0;
        end
      end
      S_RUN: begin
        fail_d = fail_q | (core_zn != ref_zn);
        if (cnt_q == 6'd63) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      fail_q  <= 1'b0;
      zn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      zn_q    <= core_zn;
    end
  end

endmodule

// File: tb/tb_oai222_x2.sv
// Randomised and directed bench for oai222_x2 against a pair-is-zero reference model.
module tb_oai222_x2;

  logic clk;
  logic rst_n;
  logic A1, A2, B1, B2, C1, C2;
  logic ZN;
  logic zn_q;

  int checks = 0;
  int errors = 0;

  oai222_x2_if bif ();

  oai222_x2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A1    (A1),
    .A2    (A2),
    .B1    (B1),
    .B2    (B2),
    .C1    (C1),
    .C2    (C2),
    .ZN    (ZN),
    .zn_q  (zn_q),
    .bist  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ZN is 1 exactly when some input pair is all-zero.
  function automatic logic model_zn(input logic [5:0] v);
    return (v[5:4] == 2'b00) || (v[3:2] == 2'b00) || (v[1:0] == 2'b00);
  endfunction

  task automatic set_pins(input logic [5:0] v);
    {A1, A2, B1, B2, C1, C2} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] pins;
    pins = 6'b110011;
    rst_n = 1'b0;
    bif.bist_start = 1'b0;
    set_pins(pins);
    #12;
    checks++;
    if (bif.bist_busy !== 1'b0 || bif.bist_done !== 1'b0 || bif.bist_fail !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b fail=%b required 000",
               bif.bist_busy, bif.bist_done, bif.bist_fail);
    end
    checks++;
    if (zn_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_zn_q: got %b required 0", zn_q);
    end
    checks++;
    if (ZN !== model_zn(pins)) begin
      errors++;
      $display("FAIL reset_zn: got %b required %b", ZN, model_zn(pins));
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_comb_sweep();
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      set_pins(v);
      #10;
      checks++;
      if (ZN !== model_zn(v)) begin
        errors++;
        $display("FAIL sweep_%b: ZN=%b required %b", v, ZN, model_zn(v));
      end
    end
    $display("test_comb_sweep: 64 vectors applied");
  endtask

  task automatic test_pair_isolation();
    set_pins(6'b100110);
    #1;
    checks++;
    if (ZN !== 1'b0) begin
      errors++;
      $display("FAIL pair_iso_base: ZN=%b required 0", ZN);
    end
    C1 = 1'b0;
    C2 = 1'b0;
    #0;
    checks++;
    if (ZN !== 1'b1) begin
      errors++;
      $display("FAIL pair_iso_c00: ZN=%b required 1", ZN);
    end
    // B pair all-zero dominates unknowns on the other pins.
    A1 = 1'bx; A2 = 1'bz; B1 = 1'b0; B2 = 1'b0; C1 = 1'bx; C2 = 1'b1;
    #1;
    checks++;
    if (ZN !== 1'b1) begin
      errors++;
      $display("FAIL pair_iso_xprop: ZN=%b required 1", ZN);
    end
    set_pins(6'b000000);
    $display("test_pair_isolation: done");
  endtask

  task automatic test_register_path();
    for (int i = 0; i < 8; i++) begin
      logic [5:0] v;
      logic       exp;
      v = (i % 2 == 0) ? 6'b111111 : 6'b000000;
      @(negedge clk);
      set_pins(v);
      #1;
      exp = model_zn(v);
      checks++;
      if (ZN !== exp) begin
        errors++;
        $display("FAIL regpath_zn_%0d: ZN=%b required %b", i, ZN, exp);
      end
      tick();
      checks++;
      if (zn_q !== exp) begin
        errors++;
        $display("FAIL regpath_zn_q_%0d: zn_q=%b required %b", i, zn_q, exp);
      end
    end
    $display("test_register_path: 8 toggles");
  endtask

  task automatic test_random();
    logic [5:0] prev;
    prev = 6'b000000;
    @(negedge clk);
    set_pins(prev);
    for (int i = 0; i < 100; i++) begin
      logic [5:0] v;
      tick();
      checks++;
      if (zn_q !== model_zn(prev)) begin
        errors++;
        $display("FAIL random_zn_q_%0d: zn_q=%b required %b", i, zn_q, model_zn(prev));
      end
      @(negedge clk);
      v = 6'($urandom_range(0, 63));
      set_pins(v);
      #1;
      checks++;
      if (ZN !== model_zn(v)) begin
        errors++;
        $display("FAIL random_zn_%0d: pins=%b ZN=%b required %b", i, v, ZN, model_zn(v));
      end
      prev = v;
    end
    $display("test_random: 100 vectors");
  endtask

  // Full BIST run: busy for 64 cycles, single done, ZN shows pattern, a start mid-run is ignored.
  task automatic test_bist_pass();
    logic [5:0] pins;
    int         done_cnt;
    pins = 6'b111111;
    done_cnt = 0;
    @(negedge clk);
    set_pins(pins);
    bif.bist_start = 1'b1;
    tick();
    bif.bist_start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k == 10) bif.bist_start = 1'b1;
      if (k == 11) bif.bist_start = 1'b0;
      if (bif.bist_done === 1'b1) done_cnt++;
      checks++;
      if (bif.bist_busy !== 1'b1 || bif.bist_done !== (k == 63) || ZN !== model_zn(6'(k))) begin
        errors++;
        $display("FAIL bist_pass_cycle_%0d: busy=%b done=%b ZN=%b required 1 %b %b",
                 k, bif.bist_busy, bif.bist_done, ZN, (k == 63), model_zn(6'(k)));
      end
      tick();
    end
    checks++;
    if (bif.bist_busy !== 1'b0 || bif.bist_done !== 1'b0 || bif.bist_fail !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL bist_pass_end: busy=%b done=%b fail=%b pulses=%0d required 0 0 0 1",
               bif.bist_busy, bif.bist_done, bif.bist_fail, done_cnt);
    end
    checks++;
    if (ZN !== model_zn(pins)) begin
      errors++;
      $display("FAIL bist_pass_pins: ZN=%b required %b", ZN, model_zn(pins));
    end
    $display("test_bist_pass: done");
  endtask

  task automatic test_bist_fault();
    @(negedge clk);
    bif.bist_start = 1'b1;
    tick();
    bif.bist_start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k == 21) force dut.core_zn = ~model_zn(6'd21);
      if (k == 22) release dut.core_zn;
      checks++;
      if (bif.bist_fail !== (k >= 22)) begin
        errors++;
        $display("FAIL bist_fault_flag_%0d: fail=%b required %b", k, bif.bist_fail, (k >= 22));
      end
      tick();
    end
    release dut.core_zn;
    checks++;
    if (bif.bist_fail !== 1'b1 || bif.bist_busy !== 1'b0) begin
      errors++;
      $display("FAIL bist_fault_sticky: fail=%b busy=%b required 1 0", bif.bist_fail, bif.bist_busy);
    end
    @(negedge clk);
    bif.bist_start = 1'b1;
    tick();
    bif.bist_start = 1'b0;
    checks++;
    if (bif.bist_fail !== 1'b0 || bif.bist_busy !== 1'b1) begin
      errors++;
      $display("FAIL bist_fault_restart: fail=%b busy=%b required 0 1", bif.bist_fail, bif.bist_busy);
    end
    for (int k = 1; k <= 64; k++) tick();
    checks++;
    if (bif.bist_fail !== 1'b0 || bif.bist_busy !== 1'b0) begin
      errors++;
      $display("FAIL bist_fault_clean_run: fail=%b busy=%b required 0 0", bif.bist_fail, bif.bist_busy);
    end
    $display("test_bist_fault: done");
  endtask

  task automatic test_reset_mid_bist();
    logic [5:0] pins;
    int         busy_cycles;
    pins = 6'b001111;
    @(negedge clk);
    set_pins(pins);
    bif.bist_start = 1'b1;
    tick();
    bif.bist_start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) force dut.core_zn = ~model_zn(6'd5);
      if (k == 6) release dut.core_zn;
      tick();
    end
    release dut.core_zn;
    checks++;
    if (bif.bist_fail !== 1'b1 || ZN !== model_zn(6'd30)) begin
      errors++;
      $display("FAIL midrst_pre: fail=%b ZN=%b required 1 %b", bif.bist_fail, ZN, model_zn(6'd30));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bif.bist_busy !== 1'b0 || bif.bist_done !== 1'b0 || bif.bist_fail !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: busy=%b done=%b fail=%b required 000",
               bif.bist_busy, bif.bist_done, bif.bist_fail);
    end
    checks++;
    if (ZN !== model_zn(pins)) begin
      errors++;
      $display("FAIL midrst_pins: ZN=%b required %b", ZN, model_zn(pins));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bif.bist_start = 1'b1;
    tick();
    bif.bist_start = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 80 && bif.bist_busy === 1'b1; k++) begin
      busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != 64 || bif.bist_fail !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rerun: busy_cycles=%0d fail=%b required 64 0", busy_cycles, bif.bist_fail);
    end
    $display("test_reset_mid_bist: done");
  endtask

  initial begin
    test_reset();
    test_comb_sweep();
    test_pair_isolation();
    test_register_path();
    test_random();
    test_bist_pass();
    test_bist_fault();
    test_reset_mid_bist();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
